// File: rtl/alu_b_operand_stage.sv
// ALU B-operand stage: selects one of NSRC packed sources and buffers it in a
// two-entry skid buffer (main + skid) toward the ALU with valid/ready flow control.
// Optional feature macro: ALU_B_SEL_CHECK_EN adds a sticky sel_err output that
// flags any accepted out-of-range select.
module alu_b_operand_stage #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       in_sel,
    input  logic [NSRC*WIDTH-1:0] in_src,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_sel
`ifdef ALU_B_SEL_CHECK_EN
    ,
    output logic                  sel_err
`endif
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mainData_q, mainData_d;
    logic [SELW-1:0]    mainSel_q, mainSel_d;
    logic [WIDTH-1:0]   skidData_q, skidData_d;
    logic [SELW-1:0]    skidSel_q, skidSel_d;
    logic               inReady_q;
    logic [WIDTH-1:0]   selData;
    logic               accept;
    logic               transfer;

    // Source multiplexer; selects beyond the last source yield all-zero data.
    always_comb begin
        selData = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_sel == SELW'(k)) begin
                selData = in_src[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept    = in_valid && inReady_q;
    assign transfer  = (state_q != EMPTY) && out_ready;
    assign in_ready  = inReady_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = mainData_q;
    assign out_sel   = mainSel_q;

    // Next-state logic for occupancy and the main/skid holding registers.
    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        mainSel_d  = mainSel_q;
        skidData_d = skidData_q;
        skidSel_d  = skidSel_q;
        if (flush) begin
            state_d    = EMPTY;
            mainData_d = '0;
            mainSel_d  = '0;
            skidData_d = '0;
            skidSel_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = ONE;
                        mainData_d = selData;
                        mainSel_d  = in_sel;
                    end
                end
                ONE: begin
                    if (accept && transfer) begin
                        mainData_d = selData;
                        mainSel_d  = in_sel;
                    end else if (accept) begin
                        state_d    = TWO;
                        skidData_d = selData;
                        skidSel_d  = in_sel;
                    end else if (transfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (transfer) begin
                        state_d    = ONE;
                        mainData_d = skidData_q;
                        mainSel_d  = skidSel_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State registers; in_ready is registered so it depends only on held state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            mainData_q <= '0;
            mainSel_q  <= '0;
            skidData_q <= '0;
            skidSel_q  <= '0;
            inReady_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            mainSel_q  <= mainSel_d;
            skidData_q <= skidData_d;
            skidSel_q  <= skidSel_d;
            inReady_q  <= (state_d != TWO);
        end
    end

`ifdef ALU_B_SEL_CHECK_EN
    logic selErr_q;
    logic selInRange;

    assign selInRange = (int'(in_sel) < NSRC);
    assign sel_err    = selErr_q;

    // Sticky out-of-range select flag; only reset clears it, flush does not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            selErr_q <= 1'b0;
        end else if (accept && !selInRange) begin
            selErr_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_b_operand_stage.sv
// Directed testbench for alu_b_operand_stage: a default NSRC=4 instance and an
// NSRC=3 instance for out-of-range select behaviour (sel_err when
// ALU_B_SEL_CHECK_EN is defined).
module tb_alu_b_operand_stage;

    logic         clk;
    logic         reset;

    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_sel;
    logic [127:0] in_src;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;

    logic         bFlush;
    logic         bInValid;
    logic         bInReady;
    logic [1:0]   bInSel;
    logic [95:0]  bInSrc;
    logic         bOutValid;
    logic         bOutReady;
    logic [31:0]  bOutData;
    logic [1:0]   bOutSel;

    int checkCount;
    int errorCount;

`ifdef ALU_B_SEL_CHECK_EN
    logic         selErrA;
    logic         selErrB;
`endif

    alu_b_operand_stage #(.WIDTH(32), .NSRC(4), .SELW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_src    (in_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef ALU_B_SEL_CHECK_EN
        ,
        .sel_err   (selErrA)
`endif
    );

    alu_b_operand_stage #(.WIDTH(32), .NSRC(3), .SELW(2)) dutB (
        .clk       (clk),
        .reset     (reset),
        .flush     (bFlush),
        .in_valid  (bInValid),
        .in_ready  (bInReady),
        .in_sel    (bInSel),
        .in_src    (bInSrc),
        .out_valid (bOutValid),
        .out_ready (bOutReady),
        .out_data  (bOutData),
        .out_sel   (bOutSel)
`ifdef ALU_B_SEL_CHECK_EN
        ,
        .sel_err   (selErrB)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] sel, input logic [31:0] src0, input logic rdy);
        in_valid     = valid;
        in_sel       = sel;
        in_src[31:0] = src0;
        out_ready    = rdy;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 2'd0;
        in_src     = '0;
        out_ready  = 1'b0;
        bFlush     = 1'b0;
        bInValid   = 1'b0;
        bInSel     = 2'd0;
        bInSrc     = '0;
        bOutReady  = 1'b0;

        // Reset state
        #7;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_out_sel", 64'(out_sel), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef ALU_B_SEL_CHECK_EN
        checkOutput("rst_sel_err", 64'(selErrB), 64'd0);
`endif
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rel_in_ready_before_edge", 64'(in_ready), 64'd0);
        tick();
        checkOutput("rel_in_ready_after_edge", 64'(in_ready), 64'd1);

        // Single operand through an empty stage, source 2
        in_src = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        in_sel = 2'd2;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("single_out_valid", 64'(out_valid), 64'd1);
        checkOutput("single_out_data", 64'(out_data), 64'h33333333);
        checkOutput("single_out_sel", 64'(out_sel), 64'd2);
        checkOutput("single_in_ready", 64'(in_ready), 64'd1);
        tick();
        checkOutput("single_empty_after", 64'(out_valid), 64'd0);

        // Fill both entries with out_ready low, then drain
        applyStimulus(1'b1, 2'd0, 32'hA, 1'b0);
        tick();
        checkOutput("fill_in_ready_one", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, 2'd0, 32'hB, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
        checkOutput("fill_in_ready_two", 64'(in_ready), 64'd0);
        checkOutput("fill_head_data", 64'(out_data), 64'hA);
        tick();
        checkOutput("stall_data_stable", 64'(out_data), 64'hA);
        checkOutput("stall_valid_stable", 64'(out_valid), 64'd1);
        checkOutput("stall_sel_stable", 64'(out_sel), 64'd0);
        out_ready = 1'b1;
        tick();
        checkOutput("drain_second_data", 64'(out_data), 64'hB);
        checkOutput("drain_second_valid", 64'(out_valid), 64'd1);
        checkOutput("drain_in_ready_back", 64'(in_ready), 64'd1);
        tick();
        checkOutput("drain_empty", 64'(out_valid), 64'd0);

        // Back-to-back stream with out_ready held high
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 2'd0, 32'(i), 1'b1);
            tick();
            checkOutput("stream_valid", 64'(out_valid), 64'd1);
            checkOutput("stream_data", 64'(out_data), 64'(i));
            checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
        end
        applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
        tick();
        checkOutput("stream_drained", 64'(out_valid), 64'd0);

        // Flush while full, with a same-cycle offer
        applyStimulus(1'b1, 2'd1, 32'h0, 1'b0);
        in_src[63:32] = 32'h111;
        tick();
        in_src[63:32] = 32'h222;
        tick();
        checkOutput("flush_pre_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        in_valid = 1'b1;
        in_src[63:32] = 32'h333;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        checkOutput("flush_out_data", 64'(out_data), 64'd0);
        checkOutput("flush_out_sel", 64'(out_sel), 64'd0);
        out_ready = 1'b1;
        tick();
        checkOutput("flush_nothing_left", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 2'd3, 32'h0, 1'b1);
        in_src[127:96] = 32'h444;
        tick();
        in_valid = 1'b0;
        checkOutput("post_flush_data", 64'(out_data), 64'h444);
        checkOutput("post_flush_sel", 64'(out_sel), 64'd3);
        tick();
        checkOutput("post_flush_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-cycle while holding one operand
        applyStimulus(1'b1, 2'd0, 32'h55, 1'b0);
        tick();
        in_valid = 1'b0;
        checkOutput("areset_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("areset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("areset_out_data", 64'(out_data), 64'd0);
        checkOutput("areset_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        tick();
        checkOutput("areset_recover_ready", 64'(in_ready), 64'd1);
        checkOutput("areset_stays_empty", 64'(out_valid), 64'd0);

        // Three-source instance: in-range and out-of-range selects
        bInSrc = {32'h33333333, 32'h22222222, 32'h11111111};
        bOutReady = 1'b1;
        bInSel = 2'd2;
        bInValid = 1'b1;
        tick();
        checkOutput("b_inrange_data", 64'(bOutData), 64'h33333333);
`ifdef ALU_B_SEL_CHECK_EN
        checkOutput("b_inrange_no_err", 64'(selErrB), 64'd0);
`endif
        bInSel = 2'd3;
        tick();
        bInValid = 1'b0;
        checkOutput("b_oor_valid", 64'(bOutValid), 64'd1);
        checkOutput("b_oor_data", 64'(bOutData), 64'd0);
        checkOutput("b_oor_sel", 64'(bOutSel), 64'd3);
`ifdef ALU_B_SEL_CHECK_EN
        checkOutput("b_sel_err_set", 64'(selErrB), 64'd1);
        checkOutput("a_sel_err_clear", 64'(selErrA), 64'd0);
`endif
        bFlush = 1'b1;
        tick();
        bFlush = 1'b0;
        checkOutput("b_flush_valid", 64'(bOutValid), 64'd0);
`ifdef ALU_B_SEL_CHECK_EN
        checkOutput("b_sel_err_after_flush", 64'(selErrB), 64'd1);
`endif
        #2;
        reset = 1'b0;
        #1;
`ifdef ALU_B_SEL_CHECK_EN
        checkOutput("b_sel_err_reset", 64'(selErrB), 64'd0);
`endif
        checkOutput("b_reset_ready", 64'(bInReady), 64'd0);
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
